imm_encoder: RTL
================

Name: imm_encoder

Overview:
- Inverse of the immediate generator: packs a 32-bit immediate value into the immediate bit fields of a RISC-V instruction word, for formats I/S/B/U/J.
- Sits in the instruction-stream generator and self-check path that feeds the pipeline front end.
- Input and output use valid/ready handshakes, with a 2-entry output FIFO for full throughput.
- Flags immediates that cannot be encoded, and keeps saturating OK and error counters.

Parameters:
- CNT_W, 16: width of the encoded-OK and error counters.
- DROP_ERR, 0: 1 = errored items are counted but not pushed to the output; 0 = pushed with out_err set.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_imm_sel  in  imm_sel_e  format, from immtypes_pkg (IMM_I/S/B/U/J)
- in_imm  in  32  immediate value to encode
- in_base  in  32  instruction with opcode/rd/rs1/rs2/funct fields; its immediate bit positions are ignored
- out_valid  out  1  output entry valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- out_instr  out  32  encoded instruction
- out_err  out  1  immediate not encodable for this format
- cnt_clr  in  1  synchronous clear of both counters
- cnt_ok  out  CNT_W  number of accepted items with err=0
- cnt_err  out  CNT_W  number of accepted items with err=1

Behaviour:
- Reset (rst_n=0 at a clk edge): FIFO empty, out_valid=0, out_instr=0, out_err=0, counters=0, in_ready=0 during reset. Reset mid-transfer discards all FIFO contents.
- Encoding is combinational on the input. Bits not listed below come from in_base.
- IMM_I: [31:20]=imm[11:0]. Error unless imm[31:11] are all equal.
- IMM_S: [31:25]=imm[11:5], [11:7]=imm[4:0]. Same range check as I.
- IMM_B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]. Error if imm[31:12] are not all equal, or imm[0]=1.
- IMM_U: [31:12]=imm[31:12]. Error if imm[11:0]!=0.
- IMM_J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]. Error if imm[31:20] are not all equal, or imm[0]=1.
- Any other sel value: out_instr=in_base, err=1.
- On error, fields are still packed from the low imm bits (truncation). out_err is set.
- Round-trip property: for err=0, immgen(out_instr, sel) == in_imm.
- FIFO: depth 2, registered.
  - in_ready = (count<2) & rst_n; it does not depend on out_ready.
  - Latency: accepted at edge N, visible at out_valid/out_instr after edge N.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Full (count=2): in_ready=0; a pop frees a slot, so in_ready=1 in the next cycle.
  - Empty: out_valid=0, and out_instr/out_err hold their last popped values.
  - out_instr/out_err stay stable while out_valid & !out_ready.
- DROP_ERR=1: an errored accept is consumed (in_ready handshake completes), counted in cnt_err, and not pushed.
- Counters increment by 1 per accepted item and saturate at all-ones.
- cnt_clr has priority over a same-cycle increment; the result is 0.

Test Plan:
- Encode all formats, base 0x00000013, DROP_ERR=0:
  - I, imm=0xFFFFF800 -> 0x80000013, err=0.
  - S, imm=0x7FF -> 0x7E000F93, err=0.
  - B, imm=0xFFFFF000 -> 0x80000013.
  - U, imm=0x12345000 -> 0x12345013.
  - J, imm=0x000FFFFE -> 0x7FFFF013.
- Errors:
  - I, imm=0x800 -> err=1, cnt_err=1.
  - B, imm=0x2 OK; B, imm=0x3 -> err=1.
  - U, imm=0x1 -> err=1.
  - DROP_ERR=1: the same item gives no out_valid, and cnt_err increments.
- Backpressure: out_ready=0, push 3 items back-to-back -> in_ready drops after 2. Raise out_ready -> outputs appear in order A, B, then C; nothing is lost or duplicated.
- Streaming: in_valid=1 and out_ready=1 for 100 random items -> one output per cycle after a 1-cycle latency. Every err=0 item round-trips through immgen to in_imm.
- Reset with 2 entries queued -> out_valid=0 and counters 0 on the next cycle. Reset assertion without a clk edge has no effect (synchronous).
- Counter saturation with CNT_W=4: 20 OK items -> cnt_ok=15. cnt_clr asserted with a simultaneous accept -> cnt_ok=0.

Source files
------------

// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into the I/S/B/U/J immediate fields
// of a RISC-V instruction word. Valid/ready on both sides, with a 2-entry registered
// output FIFO (head register plus one skid entry) and saturating OK/error counters.

package immtypes_pkg;
    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;
endpackage

module imm_encoder
    import immtypes_pkg::*;
#(
    parameter int unsigned CNT_W    = 16,
    parameter bit          DROP_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  imm_sel_e         in_imm_sel,
    input  logic [31:0]      in_imm,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_ok,
    output logic [CNT_W-1:0] cnt_err
);

    logic [31:0]      w_instr;
    logic             w_err;
    logic             w_sx11;
    logic             w_sx12;
    logic             w_sx20;
    logic             w_accept;
    logic             w_push;
    logic             w_pop;

    logic [31:0]      r_head_instr;
    logic             r_head_err;
    logic             r_head_valid;
    logic [31:0]      r_skid_instr;
    logic             r_skid_err;
    logic             r_skid_valid;
    logic [CNT_W-1:0] r_cnt_ok;
    logic [CNT_W-1:0] r_cnt_err;

    // Range checks: the immediate fits when all bits above the field's sign bit match it.
    assign w_sx11 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_sx12 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign w_sx20 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    // Pack immediate fields over the base word; errored values are still truncated in.
    always_comb begin
        w_instr = in_base;
        w_err   = 1'b0;
        case (in_imm_sel)
            IMM_I: begin
                w_instr[31:20] = in_imm[11:0];
                w_err          = ~w_sx11;
            end
            IMM_S: begin
                w_instr[31:25] = in_imm[11:5];
                w_instr[11:7]  = in_imm[4:0];
                w_err          = ~w_sx11;
            end
            IMM_B: begin
                w_instr[31]    = in_imm[12];
                w_instr[30:25] = in_imm[10:5];
                w_instr[11:8]  = in_imm[4:1];
                w_instr[7]     = in_imm[11];
                w_err          = ~w_sx12 | in_imm[0];
            end
            IMM_U: begin
                w_instr[31:12] = in_imm[31:12];
                w_err          = |in_imm[11:0];
            end
            IMM_J: begin
                w_instr[31]    = in_imm[20];
                w_instr[30:21] = in_imm[10:1];
                w_instr[20]    = in_imm[11];
                w_instr[19:12] = in_imm[19:12];
                w_err          = ~w_sx20 | in_imm[0];
            end
            default: begin
                w_instr = in_base;
                w_err   = 1'b1;
            end
        endcase
    end

    // in_ready only looks at occupancy so it never combinationally depends on out_ready.
    assign in_ready = rst_n & ~(r_head_valid & r_skid_valid);
    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & ~(DROP_ERR & w_err);
    assign w_pop    = r_head_valid & out_ready;

    // Head register drives the outputs; skid entry absorbs one item while the head stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head_instr <= 32'h0;
            r_head_err   <= 1'b0;
            r_head_valid <= 1'b0;
            r_skid_instr <= 32'h0;
            r_skid_err   <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_head_valid) begin
            if (w_pop) begin
                if (r_skid_valid) begin
                    r_head_instr <= r_skid_instr;
                    r_head_err   <= r_skid_err;
                    r_skid_valid <= w_push;
                    if (w_push) begin
                        r_skid_instr <= w_instr;
                        r_skid_err   <= w_err;
                    end
                end else if (w_push) begin
                    r_head_instr <= w_instr;
                    r_head_err   <= w_err;
                end else begin
                    // Data left in place so an empty FIFO shows the last popped entry.
                    r_head_valid <= 1'b0;
                end
            end else if (w_push) begin
                r_skid_instr <= w_instr;
                r_skid_err   <= w_err;
                r_skid_valid <= 1'b1;
            end
        end else if (w_push) begin
            r_head_instr <= w_instr;
            r_head_err   <= w_err;
            r_head_valid <= 1'b1;
        end
    end

    // Saturating counters of accepted items; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            r_cnt_ok  <= '0;
            r_cnt_err <= '0;
        end else if (w_accept) begin
            if (w_err) begin
                if (~&r_cnt_err) r_cnt_err <= r_cnt_err + CNT_W'(1);
            end else begin
                if (~&r_cnt_ok) r_cnt_ok <= r_cnt_ok + CNT_W'(1);
            end
        end
    end

    assign out_valid = r_head_valid;
    assign out_instr = r_head_instr;
    assign out_err   = r_head_err;
    assign cnt_ok    = r_cnt_ok;
    assign cnt_err   = r_cnt_err;

endmodule
